// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix stream loader: FSM state encoding,
// frame-size helpers and the flat-bus element packing rule.
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_COMMIT    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam int MATRIX_N_DEF     = 3;
    localparam int MATRIX_M_DEF     = 3;
    localparam int WIDTH_DEF        = 16;
    localparam int DONE_TIMEOUT_DEF = 1024;
    localparam int CNT_W_DEF        = 5;

    // Elements per matrix (NM) and words per frame (2NM).
    function automatic int nm_count(input int n, input int m);
        return n * m;
    endfunction

    function automatic int frame_words(input int n, input int m);
        return 2 * n * m;
    endfunction

    // Element e = r*M + c sits at bits [e*WIDTH +: WIDTH] of a flat matrix bus.
    function automatic int elem_lsb(input int e, input int width);
        return e * width;
    endfunction

endpackage

// File: rtl/done_timeout_timer.sv
// Cycle counter for the wait on compute_done; expired is high during the
// TIMEOUT-th consecutive enabled cycle since the last clear.
module done_timeout_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [31:0] count_q;

    assign expired = en && (count_q >= 32'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !expired) begin
            count_q <= count_q + 32'd1;
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// Streams two row-major matrices into shadow storage, commits both atomically
// to the flat output buses, then holds read_ready until the multiplier is done.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int MATRIX_N     = MATRIX_N_DEF,
    parameter int MATRIX_M     = MATRIX_M_DEF,
    parameter int WIDTH        = WIDTH_DEF,
    parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic                               in_valid,
    input  logic                               in_first,
    output logic                               in_ready,
    input  logic                               compute_done,
    output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] matrix_a,
    output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] matrix_b,
    output logic                               read_ready,
    output logic [CNT_W-1:0]                   load_idx,
    output logic                               frame_err,
    output logic                               busy
);

    localparam int NM  = nm_count(MATRIX_N, MATRIX_M);
    localparam int NM2 = frame_words(MATRIX_N, MATRIX_M);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NM2 - 1);

    state_t                  state_q;
    logic [CNT_W-1:0]        load_idx_q;
    logic                    read_ready_q;
    logic                    frame_err_q;
    logic [NM*WIDTH-1:0]     matrix_a_q;
    logic [NM*WIDTH-1:0]     matrix_b_q;
    logic [WIDTH-1:0]        shadow_q [NM2];

    logic accept;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    assign in_ready   = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_IDLE);
    assign accept     = in_valid && in_ready;
    assign read_ready = read_ready_q;
    assign load_idx   = load_idx_q;
    assign frame_err  = frame_err_q;
    assign matrix_a   = matrix_a_q;
    assign matrix_b   = matrix_b_q;

    assign timer_en  = (state_q == ST_WAIT_DONE);
    assign timer_clr = clear || !timer_en;

    done_timeout_timer #(
        .TIMEOUT (DONE_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            load_idx_q   <= '0;
            read_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            matrix_a_q   <= '0;
            matrix_b_q   <= '0;
            for (int e = 0; e < NM2; e++) begin
                shadow_q[e] <= '0;
            end
        end else if (clear) begin
            // Restart the frame; shadow and committed data are left untouched.
            state_q      <= ST_LOAD;
            load_idx_q   <= '0;
            read_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (in_first && (load_idx_q != '0)) begin
                            // Resync: restart the frame with this word as A[0][0].
                            shadow_q[0] <= in_data;
                            load_idx_q  <= CNT_W'(1);
                            frame_err_q <= 1'b1;
                        end else begin
                            shadow_q[load_idx_q] <= in_data;
                            if (load_idx_q == LAST_IDX) begin
                                load_idx_q <= '0;
                                state_q    <= ST_COMMIT;
                            end else begin
                                load_idx_q <= load_idx_q + CNT_W'(1);
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    for (int e = 0; e < NM; e++) begin
                        matrix_a_q[elem_lsb(e, WIDTH) +: WIDTH] <= shadow_q[e];
                        matrix_b_q[elem_lsb(e, WIDTH) +: WIDTH] <= shadow_q[NM + e];
                    end
                    read_ready_q <= 1'b1;
                    state_q      <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (compute_done) begin
                        read_ready_q <= 1'b0;
                        state_q      <= ST_LOAD;
                    end else if (timer_expired) begin
                        read_ready_q <= 1'b0;
                        frame_err_q  <= 1'b1;
                        state_q      <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Randomized self-checking bench for matrix_stream_loader against a frame-level
// model of shadow words, committed matrices, expected index and error flag.
module tb_matrix_stream_loader;

    localparam int N   = 3;
    localparam int M   = 3;
    localparam int W   = 16;
    localparam int TO  = 16;
    localparam int CW  = 5;
    localparam int NM  = N * M;
    localparam int NM2 = 2 * NM;
    localparam int BW  = NM * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_first;
    logic          in_ready;
    logic          compute_done;
    logic [BW-1:0] matrix_a;
    logic [BW-1:0] matrix_b;
    logic          read_ready;
    logic [CW-1:0] load_idx;
    logic          frame_err;
    logic          busy;

    matrix_stream_loader #(
        .MATRIX_N     (N),
        .MATRIX_M     (M),
        .WIDTH        (W),
        .DONE_TIMEOUT (TO),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_first     (in_first),
        .in_ready     (in_ready),
        .compute_done (compute_done),
        .matrix_a     (matrix_a),
        .matrix_b     (matrix_b),
        .read_ready   (read_ready),
        .load_idx     (load_idx),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int frames   = 0;

    // Reference model: words of the frame in progress and the committed matrices.
    logic [W-1:0] shadow_m [NM2];
    logic [W-1:0] com_a    [NM];
    logic [W-1:0] com_b    [NM];
    int           exp_idx;
    bit           exp_err;
    bit           commit_pending;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] packed_ref(input bit is_b);
        logic [BW-1:0] v;
        v = '0;
        for (int e = 0; e < NM; e++) begin
            v[e*W +: W] = is_b ? com_b[e] : com_a[e];
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int e = 0; e < NM2; e++) shadow_m[e] = '0;
        for (int e = 0; e < NM; e++) begin
            com_a[e] = '0;
            com_b[e] = '0;
        end
        exp_idx        = 0;
        exp_err        = 1'b0;
        commit_pending = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input bit f, input int gap);
        repeat (gap) begin
            in_valid = 1'b0;
            tick();
            check_eq("gap_idx", BW'(load_idx), BW'(exp_idx));
        end
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        check_eq("in_ready_load", BW'(in_ready), BW'(1));
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        if (f && exp_idx != 0) begin
            shadow_m[0] = d;
            exp_idx     = 1;
            exp_err     = 1'b1;
        end else begin
            shadow_m[exp_idx] = d;
            exp_idx++;
            if (exp_idx == NM2) begin
                exp_idx        = 0;
                commit_pending = 1'b1;
            end
        end
        check_eq("load_idx", BW'(load_idx), BW'(exp_idx));
        check_eq("frame_err", BW'(frame_err), BW'(exp_err));
        check_eq("hold_a", matrix_a, packed_ref(1'b0));
        check_eq("hold_b", matrix_b, packed_ref(1'b1));
    endtask

    // Cycle after the last accept: still COMMIT; the next edge publishes.
    task automatic commit_step();
        check_eq("commit_pending", BW'(commit_pending), BW'(1));
        check_eq("rr_in_commit", BW'(read_ready), BW'(0));
        check_eq("in_ready_commit", BW'(in_ready), BW'(0));
        tick();
        for (int e = 0; e < NM; e++) begin
            com_a[e] = shadow_m[e];
            com_b[e] = shadow_m[NM + e];
        end
        commit_pending = 1'b0;
        frames++;
        check_eq("rr_rise", BW'(read_ready), BW'(1));
        check_eq("commit_a", matrix_a, packed_ref(1'b0));
        check_eq("commit_b", matrix_b, packed_ref(1'b1));
        check_eq("in_ready_wait", BW'(in_ready), BW'(0));
        check_eq("busy_wait", BW'(busy), BW'(1));
        $display("frame %0d committed: a0=%04h b8=%04h err=%0d", frames, com_a[0], com_b[NM-1], frame_err);
    endtask

    task automatic send_frame(input bit use_first, input bit gaps, input bit seq);
        for (int i = 0; i < NM2; i++) begin
            send(seq ? W'(i + 1) : W'($urandom), use_first && (i == 0),
                 gaps ? int'($urandom_range(0, 3)) : 0);
        end
        commit_step();
    endtask

    // compute_done goes high `delay` cycles after read_ready rose.
    task automatic finish_done(input int delay);
        repeat (delay - 1) begin
            tick();
            check_eq("rr_hold", BW'(read_ready), BW'(1));
        end
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        check_eq("rr_fall_done", BW'(read_ready), BW'(0));
        check_eq("in_ready_after_done", BW'(in_ready), BW'(1));
        check_eq("err_after_done", BW'(frame_err), BW'(exp_err));
    endtask

    task automatic do_clear(input bit with_word);
        in_valid = with_word;
        in_data  = W'($urandom);
        in_first = 1'b0;
        clear    = 1'b1;
        tick();
        clear          = 1'b0;
        in_valid       = 1'b0;
        exp_idx        = 0;
        exp_err        = 1'b0;
        commit_pending = 1'b0;
        check_eq("clear_idx", BW'(load_idx), BW'(0));
        check_eq("clear_rr", BW'(read_ready), BW'(0));
        check_eq("clear_err", BW'(frame_err), BW'(0));
        check_eq("clear_in_ready", BW'(in_ready), BW'(1));
        check_eq("clear_a", matrix_a, packed_ref(1'b0));
        check_eq("clear_b", matrix_b, packed_ref(1'b1));
    endtask

    initial begin
        int hi_cnt;
        reset        = 1'b0;
        clear        = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        in_first     = 1'b0;
        compute_done = 1'b0;
        model_reset();

        tick();
        tick();
        check_eq("rst_in_ready", BW'(in_ready), BW'(0));
        check_eq("rst_rr", BW'(read_ready), BW'(0));
        check_eq("rst_idx", BW'(load_idx), BW'(0));
        check_eq("rst_err", BW'(frame_err), BW'(0));
        check_eq("rst_busy", BW'(busy), BW'(0));
        check_eq("rst_a", matrix_a, '0);
        check_eq("rst_b", matrix_b, '0);
        reset = 1'b1;
        tick();
        tick();
        check_eq("start_in_ready", BW'(in_ready), BW'(1));
        check_eq("start_busy", BW'(busy), BW'(1));

        // Normal frame: words 1..18, flagged.
        send_frame(1'b1, 1'b0, 1'b1);
        check_eq("a_first", BW'(matrix_a[15:0]), BW'(1));
        check_eq("a_last", BW'(matrix_a[143:128]), BW'(9));
        check_eq("b_first", BW'(matrix_b[15:0]), BW'(10));
        check_eq("b_last", BW'(matrix_b[143:128]), BW'(18));
        check_eq("normal_err", BW'(frame_err), BW'(0));
        finish_done(5);

        // Random frames with gaps and random flagging.
        for (int k = 0; k < 3; k++) begin
            compute_done = 1'b1;  // ignored outside WAIT_DONE
            send_frame(1'($urandom), 1'b1, 1'b0);
            compute_done = 1'b0;
            finish_done(int'($urandom_range(1, 10)));
        end

        // Resync in the middle of a frame.
        for (int i = 0; i < 4; i++) send(W'($urandom), i == 0, 0);
        send(16'h00AA, 1'b1, 0);
        check_eq("resync_err", BW'(frame_err), BW'(1));
        check_eq("resync_idx", BW'(load_idx), BW'(1));
        for (int i = 0; i < NM2 - 1; i++) send(W'($urandom), 1'b0, int'($urandom_range(0, 1)));
        commit_step();
        check_eq("resync_a0", BW'(matrix_a[15:0]), BW'(16'h00AA));
        finish_done(3);
        do_clear(1'b0);

        // Timeout with compute_done never asserted.
        send_frame(1'b1, 1'b0, 1'b0);
        hi_cnt = 1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (!read_ready) break;
            hi_cnt++;
        end
        exp_err = 1'b1;
        check_eq("timeout_cycles", BW'(hi_cnt), BW'(TO));
        check_eq("timeout_rr", BW'(read_ready), BW'(0));
        check_eq("timeout_err", BW'(frame_err), BW'(1));
        check_eq("timeout_in_ready", BW'(in_ready), BW'(1));

        // Clear mid-frame, coincident with a valid word that must be dropped.
        for (int i = 0; i < 7; i++) send(W'($urandom), i == 0, 0);
        do_clear(1'b1);
        send_frame(1'b0, 1'b1, 1'b0);

        // Async reset during WAIT_DONE.
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_eq("arst_rr", BW'(read_ready), BW'(0));
        check_eq("arst_a", matrix_a, '0);
        check_eq("arst_b", matrix_b, '0);
        check_eq("arst_in_ready", BW'(in_ready), BW'(0));
        check_eq("arst_idx", BW'(load_idx), BW'(0));
        #1 reset = 1'b1;
        #0;
        check_eq("arst_release_in_ready", BW'(in_ready), BW'(0));
        tick();
        tick();
        check_eq("arst_back_in_ready", BW'(in_ready), BW'(1));

        // One more frame after reset recovery.
        send_frame(1'b1, 1'b1, 1'b0);
        finish_done(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
